// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, FSM encoding and inverse round helpers
package aes_pkg;

    localparam int NR_AES256 = 14;
    localparam int BLOCK_W   = 128;
    localparam int KEY_W     = 256;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ROUND = ST_ROUND,
        FINAL = ST_FINAL,
        HOLD  = ST_HOLD
    } fsm_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte (r,c) lives at bits [127-8*(4c+r) -: 8]; row r rotates right by r.
    function automatic logic [BLOCK_W-1:0] inv_shift_rows(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [BLOCK_W-1:0] inv_mix_columns(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32*c -: 32] = inv_mix_column(s[127 - 32*c -: 32]);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes256_decrypt_core_if.sv
// rtl/aes256_decrypt_core_if.sv - request, key-store and result signals of the decrypt core
interface aes256_decrypt_core_if #(
    parameter int RKW = 4
);
    import aes_pkg::*;

    logic               start;
    logic [BLOCK_W-1:0] ciphertext;
    logic               key_ready;
    logic [RKW-1:0]     rk_idx;
    logic [BLOCK_W-1:0] rk_data;
    logic               busy;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] plaintext;
    logic               key_err;

    modport master (
        output start, ciphertext, key_ready, rk_data, out_ready,
        input  rk_idx, busy, out_valid, plaintext, key_err
    );

    modport slave (
        input  start, ciphertext, key_ready, rk_data, out_ready,
        output rk_idx, busy, out_valid, plaintext, key_err
    );

endinterface

// File: rtl/inv_sbox.sv
// rtl/inv_sbox.sv - AES inverse S-box, combinational 256-entry ROM
module inv_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign out_byte = INV_SBOX[in_byte];

endmodule

// File: rtl/aes256_decrypt_core.sv
// rtl/aes256_decrypt_core.sv - iterative AES-256 inverse cipher, one round per clock
module aes256_decrypt_core
    import aes_pkg::*;
#(
    parameter int NR  = NR_AES256,
    parameter int RKW = 4
) (
    input  logic                clk,
    input  logic                rst,
    aes256_decrypt_core_if.slave bus
);

    fsm_state_t         state;
    logic [RKW-1:0]     cnt;
    logic [BLOCK_W-1:0] state_reg;
    logic [BLOCK_W-1:0] plaintext_q;
    logic               out_valid_q;
    logic               busy_q;
    logic               key_err_q;

    logic [BLOCK_W-1:0] sr;
    logic [BLOCK_W-1:0] sb;
    logic [BLOCK_W-1:0] final_out;
    logic [BLOCK_W-1:0] round_out;

    assign sr = inv_shift_rows(state_reg);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .in_byte (sr[8*i +: 8]),
            .out_byte(sb[8*i +: 8])
        );
    end

    assign final_out = sb ^ bus.rk_data;
    assign round_out = inv_mix_columns(final_out);

    // Key-store address depends only on FSM state and round counter.
    always_comb begin
        bus.rk_idx = RKW'(NR);
        case (state)
            ROUND:   bus.rk_idx = cnt;
            FINAL:   bus.rk_idx = '0;
            default: bus.rk_idx = RKW'(NR);
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.plaintext = plaintext_q;
    assign bus.key_err   = key_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            state_reg   <= '0;
            plaintext_q <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            key_err_q   <= 1'b0;
        end else begin
            key_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && bus.key_ready) begin
                        state_reg <= bus.ciphertext ^ bus.rk_data;
                        cnt       <= RKW'(NR - 1);
                        busy_q    <= 1'b1;
                        state     <= ROUND;
                    end
                end
                ROUND: begin
                    if (!bus.key_ready) begin
                        busy_q    <= 1'b0;
                        key_err_q <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        state_reg <= round_out;
                        if (cnt == RKW'(1)) begin
                            state <= FINAL;
                        end else begin
                            cnt <= cnt - RKW'(1);
                        end
                    end
                end
                FINAL: begin
                    if (!bus.key_ready) begin
                        busy_q    <= 1'b0;
                        key_err_q <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        plaintext_q <= final_out;
                        out_valid_q <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    // Result is complete here, so key_ready is no longer watched.
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes256_decrypt_core.sv
// tb/tb_aes256_decrypt_core.sv - directed and round-trip bench for aes256_decrypt_core
module tb_aes256_decrypt_core;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes256_decrypt_core_if #(.RKW(4)) bus ();

    aes256_decrypt_core #(.NR(14), .RKW(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    logic [127:0] rk [16];
    assign bus.rk_data = rk[bus.rk_idx];

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;

    task automatic check(input logic [127:0] obs, input logic [127:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // Forward S-box from the field inverse (a^254) and the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] t;
        logic [7:0] r;
        t = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            t = gmul(t, t);
            r = gmul(r, t);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    task automatic expand_key(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        rk[15] = '0;
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [127:0] s;
        logic [127:0] o;
        logic [7:0]   a [4];
        s = pt ^ rk[0];
        for (int rnd = 1; rnd <= 14; rnd++) begin
            for (int k = 0; k < 16; k++) s[127 - 8*k -: 8] = sbox(s[127 - 8*k -: 8]);
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            s = o;
            if (rnd < 14) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = s[127 - 8*(4*c + r) -: 8];
                    for (int r = 0; r < 4; r++)
                        s[127 - 8*(4*c + r) -: 8] = xt(a[r]) ^ xt(a[(r+1)%4]) ^ a[(r+1)%4]
                                                    ^ a[(r+2)%4] ^ a[(r+3)%4];
                end
            end
            s = s ^ rk[rnd];
        end
        return s;
    endfunction

    // Entered at a negedge; returns at the negedge where out_valid is first seen.
    task automatic decrypt(input logic [127:0] ct, input logic [127:0] exp_pt, input string tag);
        int         lat;
        bit         seq_ok;
        logic [3:0] exp_idx;
        seq_ok = (bus.rk_idx === 4'd14);
        bus.ciphertext = ct;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.ciphertext = {$urandom, $urandom, $urandom, $urandom};
        lat = -1;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            @(negedge clk);
            exp_idx = (k < 13) ? 4'(13 - k) : ((k == 13) ? 4'd0 : 4'd14);
            if (bus.rk_idx !== exp_idx) seq_ok = 1'b0;
            if (bus.out_valid === 1'b1) lat = k;
        end
        check(128'(lat), 128'd14, {tag, " latency"});
        check(128'(seq_ok), 128'd1, {tag, " rk_idx sequence"});
        check(bus.plaintext, exp_pt, {tag, " plaintext"});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] pt2;
        logic [127:0] ct2;
        logic [127:0] pt;
        logic [255:0] key;
        bit           hold_ok;
        bit           found;
        bit           ov_seen;

        rst = 1'b1;
        bus.start = 1'b0;
        bus.ciphertext = '0;
        bus.key_ready = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) rk[i] = '0;
        repeat (3) @(negedge clk);
        check(128'(bus.busy), 128'd0, "reset busy");
        check(128'(bus.out_valid), 128'd0, "reset out_valid");
        check(bus.plaintext, 128'd0, "reset plaintext");
        check(128'(bus.key_err), 128'd0, "reset key_err");
        check(128'(bus.rk_idx), 128'd14, "reset rk_idx");
        rst = 1'b0;
        expand_key(C3_KEY);

        // Start while key schedule is not ready is ignored.
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check(128'(bus.busy), 128'd0, "no key busy");
        check(128'(bus.rk_idx), 128'd14, "no key rk_idx");
        bus.key_ready = 1'b1;

        @(negedge clk);
        decrypt(C3_CT, C3_PT, "c3");
        @(negedge clk);
        check(128'(bus.out_valid), 128'd0, "c3 out_valid drop");
        check(128'(bus.busy), 128'd0, "c3 busy drop");

        // Backpressure: result held, start ignored.
        bus.out_ready = 1'b0;
        decrypt(C3_CT, C3_PT, "bp");
        hold_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!(bus.out_valid === 1'b1 && bus.busy === 1'b1 && bus.plaintext === C3_PT
                  && bus.rk_idx === 4'd14)) hold_ok = 1'b0;
            if (i == 5) begin
                bus.ciphertext = 128'hdeadbeef;
                bus.start = 1'b1;
            end
            if (i == 6) bus.start = 1'b0;
        end
        check(128'(hold_ok), 128'd1, "bp hold stable");
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check(128'(bus.out_valid), 128'd0, "bp out_valid drop");
        check(128'(bus.busy), 128'd0, "bp busy drop");
        pt2 = 128'h0123456789abcdeffedcba9876543210;
        ct2 = encrypt(pt2);
        @(negedge clk);
        decrypt(ct2, pt2, "bp next");
        @(negedge clk);

        // key_ready falls in ROUND at cnt=7.
        bus.ciphertext = C3_CT;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        found = 1'b0;
        ov_seen = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) ov_seen = 1'b1;
            if (bus.rk_idx === 4'd7) found = 1'b1;
        end
        check(128'(found), 128'd1, "abort reach cnt7");
        bus.key_ready = 1'b0;
        @(negedge clk);
        check(128'(bus.key_err), 128'd1, "abort key_err pulse");
        check(128'(bus.busy), 128'd0, "abort busy");
        check(bus.plaintext, pt2, "abort plaintext kept");
        if (bus.out_valid === 1'b1) ov_seen = 1'b1;
        @(negedge clk);
        check(128'(bus.key_err), 128'd0, "abort key_err single");
        check(128'(bus.rk_idx), 128'd14, "abort rk_idx idle");
        if (bus.out_valid === 1'b1) ov_seen = 1'b1;
        bus.key_ready = 1'b1;
        repeat (16) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) ov_seen = 1'b1;
        end
        check(128'(ov_seen), 128'd0, "abort no out_valid");

        // Asynchronous reset in the middle of an operation.
        bus.ciphertext = C3_CT;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check(128'(bus.busy), 128'd0, "midrst busy");
        check(128'(bus.out_valid), 128'd0, "midrst out_valid");
        check(bus.plaintext, 128'd0, "midrst plaintext");
        check(128'(bus.key_err), 128'd0, "midrst key_err");
        check(128'(bus.rk_idx), 128'd14, "midrst rk_idx");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        decrypt(C3_CT, C3_PT, "post rst c3");
        @(negedge clk);

        // Round-trip against the bench's own forward cipher.
        for (int n = 0; n < 1000; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            expand_key(key);
            decrypt(encrypt(pt), pt, "roundtrip");
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
